// File: rtl/hdc_assoc_search_if.sv
// Handshake and class-memory bundle for the HDC associative search block.
// The master side is the environment (encoder, class memory, result consumer).
`ifndef DIM
`define DIM 1024
`endif

interface hdc_assoc_search_if #(
  parameter int NUM_CLASS = 16,
  parameter int CW        = $clog2(NUM_CLASS),
  parameter int DSW       = $clog2(`DIM) + 1
);
  logic              query_valid;
  logic              query_ready;
  logic [`DIM-1:0]   query;
  logic              mem_rd_en;
  logic [CW-1:0]     mem_rd_addr;
  logic [`DIM-1:0]   mem_rd_data;
  logic              res_valid;
  logic              res_ready;
  logic [CW-1:0]     res_class;
  logic [DSW-1:0]    res_dist;

  modport master (
    output query_valid, query, mem_rd_data, res_ready,
    input  query_ready, mem_rd_en, mem_rd_addr, res_valid, res_class, res_dist
  );

  modport slave (
    input  query_valid, query, mem_rd_data, res_ready,
    output query_ready, mem_rd_en, mem_rd_addr, res_valid, res_class, res_dist
  );
endinterface

// File: rtl/hdc_assoc_search.sv
// Nearest-class search: streams every class hypervector past the query and
// keeps the index/Hamming distance of the closest one (lowest index on ties).
`ifndef DIM
`define DIM 1024
`endif

module hdc_similarity #(
  parameter int DATA_W = `DIM,
  parameter int DSW    = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DSW-1:0]    simi_p1
);
  function automatic logic [DSW-1:0] popcount(input logic [DATA_W-1:0] v);
    logic [DSW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DATA_W; i++) cnt = cnt + DSW'(v[i]);
    return cnt;
  endfunction

  // stage p0 -> p1: registered Hamming distance
  always_ff @(posedge clk) simi_p1 <= popcount(a ^ b);
endmodule

module hdc_assoc_search #(
  parameter int NUM_CLASS = 16,
  parameter int CW        = $clog2(NUM_CLASS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hdc_assoc_search_if.slave    bus,
  output logic                 busy
);
  localparam int DSW = $clog2(`DIM) + 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_CLASS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [`DIM-1:0]  query_q;
  logic [CW-1:0]    addr;
  logic             first_flag;
  logic             rd_vld_p1;
  logic [CW-1:0]    rd_tag_p1;
  logic             sim_vld_p2;
  logic [CW-1:0]    sim_tag_p2;
  logic [DSW-1:0]   simi_p2;
  logic [DSW-1:0]   min_dist;
  logic [CW-1:0]    min_class;
  logic             accept;
  logic             res_fire;
  logic             take;

  assign bus.query_ready = (state == S_IDLE);
  assign bus.mem_rd_en   = (state == S_SCAN);
  assign bus.mem_rd_addr = addr;
  assign bus.res_valid   = (state == S_DONE);
  assign bus.res_class   = min_class;
  assign bus.res_dist    = min_dist;
  assign busy            = (state != S_IDLE);

  assign accept   = bus.query_valid && bus.query_ready;
  assign res_fire = bus.res_valid && bus.res_ready;
  // Strict less-than keeps the earliest (lowest-index) class on equal distance
  assign take     = sim_vld_p2 && (first_flag || (simi_p2 < min_dist));

  // stage p1 -> p2: class data arrives one cycle after its read
  hdc_similarity #(.DATA_W(`DIM), .DSW(DSW)) u_sim (
    .clk     (clk),
    .a       (query_q),
    .b       (bus.mem_rd_data),
    .simi_p1 (simi_p2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      query_q    <= '0;
      addr       <= '0;
      first_flag <= 1'b0;
      rd_vld_p1  <= 1'b0;
      rd_tag_p1  <= '0;
      sim_vld_p2 <= 1'b0;
      sim_tag_p2 <= '0;
      min_dist   <= '0;
      min_class  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            query_q    <= bus.query;
            addr       <= '0;
            first_flag <= 1'b1;
            state      <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (addr == LAST) state <= S_DRAIN;
          else              addr  <= addr + CW'(1);
        end
        S_DRAIN: begin
          if (sim_vld_p2 && (sim_tag_p2 == LAST)) state <= S_DONE;
        end
        default: begin
          if (res_fire) state <= S_IDLE;
        end
      endcase

      // stage p0 -> p1: tag the issued read
      rd_vld_p1  <= (state == S_SCAN);
      rd_tag_p1  <= addr;
      // stage p1 -> p2: align tag with the registered distance
      sim_vld_p2 <= rd_vld_p1;
      sim_tag_p2 <= rd_tag_p1;

      if (take) begin
        min_dist   <= simi_p2;
        min_class  <= sim_tag_p2;
        first_flag <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_hdc_assoc_search.sv
// Randomized bench for hdc_assoc_search against a brute-force nearest-class model.
`ifndef DIM
`define DIM 1024
`endif

module tb_hdc_assoc_search;
  localparam int NC  = 16;
  localparam int DIM = `DIM;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   total = 0;
  int   bad = 0;

  logic [DIM-1:0] cls [NC];
  int             rd_log[$];

  hdc_assoc_search_if #(.NUM_CLASS(NC)) bus ();

  hdc_assoc_search #(.NUM_CLASS(NC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Class memory: data returned one cycle after the strobe, noise otherwise
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rd_data <= cls[bus.mem_rd_addr];
      rd_log.push_back(int'(bus.mem_rd_addr));
    end else begin
      for (int w = 0; w < DIM / 32; w++) bus.mem_rd_data[w*32 +: 32] <= $urandom;
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DIM-1:0] rand_vec();
    logic [DIM-1:0] r;
    for (int w = 0; w < DIM / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DIM-1:0] flip(input logic [DIM-1:0] v, input int n);
    int start;
    start = $urandom_range(0, DIM - 1);
    for (int i = 0; i < n; i++) v[(start + i) % DIM] = ~v[(start + i) % DIM];
    return v;
  endfunction

  // Reference: brute-force Hamming distance, first minimum wins
  task automatic ref_model(input logic [DIM-1:0] q, output int c, output int d);
    int di;
    c = 0;
    d = DIM + 1;
    for (int i = 0; i < NC; i++) begin
      di = $countones(q ^ cls[i]);
      if (di < d) begin
        d = di;
        c = i;
      end
    end
  endtask

  // Runs one query starting at a negedge; returns at the negedge where the result was seen
  // (or, with hold>0, one cycle after the delayed result handshake).
  task automatic do_query(input logic [DIM-1:0] q, input int exp_c, input int exp_d,
                          input int hold, input bit keep_valid);
    int lat;
    int wait_cnt;
    int badord;
    int held_c;
    int held_d;
    @(negedge clk);
    bus.query       = q;
    bus.query_valid = 1'b1;
    bus.res_ready   = (hold == 0);
    wait_cnt = 0;
    while (!bus.query_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!bus.query_ready) begin
      chk("accept_timeout", 0, 1);
      bus.query_valid = 1'b0;
      return;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if (!keep_valid) bus.query_valid = 1'b0;
        bus.query = rand_vec();
        rd_log.delete();
      end
    end while (!bus.res_valid && lat < 60);
    chk("latency", lat, 19);
    chk("res_class", bus.res_class, exp_c);
    chk("res_dist", bus.res_dist, exp_d);
    chk("rd_count", rd_log.size(), NC);
    badord = 0;
    foreach (rd_log[i]) if (rd_log[i] != i) badord++;
    chk("rd_order", badord, 0);
    if (hold > 0) begin
      held_c = int'(bus.res_class);
      held_d = int'(bus.res_dist);
      for (int h = 0; h < hold; h++) begin
        chk("bp_valid", bus.res_valid, 1);
        chk("bp_class", bus.res_class, held_c);
        chk("bp_dist", bus.res_dist, held_d);
        chk("bp_qready", bus.query_ready, 0);
        bus.query_valid = (h == 4);
        @(negedge clk);
      end
      bus.query_valid = 1'b0;
      bus.res_ready   = 1'b1;
      @(negedge clk);
      chk("post_qready", bus.query_ready, 1);
      chk("post_valid", bus.res_valid, 0);
      chk("post_class", bus.res_class, held_c);
      chk("post_busy", busy, 0);
    end else if (!keep_valid) begin
      @(negedge clk);
      chk("post_qready", bus.query_ready, 1);
      chk("post_valid", bus.res_valid, 0);
    end
  endtask

  initial begin
    logic [DIM-1:0] q;
    int ec;
    int ed;
    int tgt[4];
    rst_n           = 1'b0;
    bus.query_valid = 1'b0;
    bus.query       = '0;
    bus.res_ready   = 1'b1;
    foreach (cls[i]) cls[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_rd_addr", bus.mem_rd_addr, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_class", bus.res_class, 0);
    chk("rst_res_dist", bus.res_dist, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_qready", bus.query_ready, 1);

    // Nearest match: class 5 is 3 bits away, the rest 100+i
    q = rand_vec();
    for (int i = 0; i < NC; i++) cls[i] = flip(q, 100 + i);
    cls[5] = flip(q, 3);
    do_query(q, 5, 3, 0, 1'b0);

    // Tie-break: classes 2 and 9 equal the query
    q = rand_vec();
    for (int i = 0; i < NC; i++) cls[i] = flip(q, 50);
    cls[2] = q;
    cls[9] = q;
    do_query(q, 2, 0, 0, 1'b0);

    // Maximum distance: every class is the complement
    q = rand_vec();
    for (int i = 0; i < NC; i++) cls[i] = ~q;
    do_query(q, 0, DIM, 0, 1'b0);

    // Randomized tables, some with a planted near neighbour
    for (int t = 0; t < 4; t++) begin
      q = rand_vec();
      for (int i = 0; i < NC; i++) cls[i] = rand_vec();
      if (t != 0) cls[$urandom_range(0, NC - 1)] = flip(q, $urandom_range(0, 40));
      ref_model(q, ec, ed);
      do_query(q, ec, ed, 0, 1'b0);
    end

    // Backpressure on the result port
    q = rand_vec();
    for (int i = 0; i < NC; i++) cls[i] = rand_vec();
    cls[11] = flip(q, 7);
    ref_model(q, ec, ed);
    do_query(q, ec, ed, 10, 1'b0);

    // Reset during cycle 8 of the scan
    q = rand_vec();
    for (int i = 0; i < NC; i++) cls[i] = rand_vec();
    cls[4] = flip(q, 1);
    @(negedge clk);
    bus.query       = q;
    bus.query_valid = 1'b1;
    @(negedge clk);
    bus.query_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_rd_en", bus.mem_rd_en, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en", bus.mem_rd_en, 0);
    chk("mid_rst_valid", bus.res_valid, 0);
    chk("mid_rst_class", bus.res_class, 0);
    chk("mid_rst_dist", bus.res_dist, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q = rand_vec();
    for (int i = 0; i < NC; i++) cls[i] = rand_vec();
    cls[7] = q;
    do_query(q, 7, 0, 0, 1'b0);

    // Back-to-back queries with query_valid and res_ready held high
    for (int i = 0; i < NC; i++) cls[i] = rand_vec();
    tgt[0] = 0; tgt[1] = 15; tgt[2] = 3; tgt[3] = 3;
    for (int k = 0; k < 4; k++) begin
      q = (k == 3) ? flip(cls[3], 2) : cls[tgt[k]];
      do_query(q, tgt[k], (k == 3) ? 2 : 0, 0, 1'b1);
    end
    bus.query_valid = 1'b0;
    @(negedge clk);
    chk("b2b_end_qready", bus.query_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
